jump_field_encoder: RTL and testbench

JUMP_FIELD_ENCODER -- requirements
Module: jump_field_encoder

---
 rtl/jump_field_encoder.sv | 88 ++++++++
 tb/tb_jump_field_encoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/jump_field_encoder.sv
// jump_field_encoder: encodes J-format instr_index and error flags from a jump target, with a
// two-entry output/skid buffer and saturating delivery statistics.
module jump_field_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        target,
    input  logic [31:0]        pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [25:0]        instr_index,
    output logic               misaligned,
    output logic               region_err,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state_q;
    logic [25:0]        out_idx_q, skid_idx_q;
    logic               out_mis_q, out_rgn_q, skid_mis_q, skid_rgn_q;
    logic [COUNT_W-1:0] enc_q, err_q;
    logic [3:0]         pc4_hi;
    logic               acc, dlv, new_mis, new_rgn;

    assign in_ready    = state_q != TWO;
    assign out_valid   = state_q != EMPTY;
    assign acc         = in_valid && in_ready;
    assign dlv         = out_valid && out_ready;
    assign pc4_hi      = 4'((pc + 32'd4) >> 28);
    assign new_mis     = target[1:0] != 2'b00;
    assign new_rgn     = target[31:28] != pc4_hi;
    assign instr_index = out_idx_q;
    assign misaligned  = out_mis_q;
    assign region_err  = out_rgn_q;
    assign enc_count   = enc_q;
    assign err_count   = err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= EMPTY;
            out_idx_q  <= '0;
            out_mis_q  <= 1'b0;
            out_rgn_q  <= 1'b0;
            skid_idx_q <= '0;
            skid_mis_q <= 1'b0;
            skid_rgn_q <= 1'b0;
            enc_q      <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    state_q   <= ONE;
                    out_idx_q <= target[27:2];
                    out_mis_q <= new_mis;
                    out_rgn_q <= new_rgn;
                end
                ONE: if (acc && !dlv) begin
                    state_q    <= TWO;
                    skid_idx_q <= target[27:2];
                    skid_mis_q <= new_mis;
                    skid_rgn_q <= new_rgn;
                end else if (dlv && !acc) begin
                    state_q <= EMPTY;
                end else if (acc) begin
                    out_idx_q <= target[27:2];
                    out_mis_q <= new_mis;
                    out_rgn_q <= new_rgn;
                end
                TWO: if (dlv) begin
                    state_q   <= ONE;
                    out_idx_q <= skid_idx_q;
                    out_mis_q <= skid_mis_q;
                    out_rgn_q <= skid_rgn_q;
                end
                default: state_q <= EMPTY;
            endcase
            // counters stick at all-ones instead of wrapping
            if (dlv) begin
                enc_q <= enc_q + COUNT_W'(enc_q != '1);
                if (out_mis_q || out_rgn_q) err_q <= err_q + COUNT_W'(err_q != '1);
            end
        end
    end
endmodule

// File: tb/tb_jump_field_encoder.sv
// tb_jump_field_encoder: directed vectors plus a queue-based reference model checked every cycle.
module tb_jump_field_encoder;
    localparam int CW = 4;

    logic          Clk = 1'b0, Rst_n = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0]   target = '0, pc = '0;
    logic          in_ready, out_valid, misaligned, region_err;
    logic [25:0]   instr_index;
    logic [CW-1:0] enc_count, err_count;

    int n_chk = 0, n_fail = 0;
    logic [27:0] q[$];
    int m_enc = 0, m_err = 0;
    localparam int SAT = (1 << CW) - 1;

    jump_field_encoder #(.COUNT_W(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .target(target), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .instr_index(instr_index), .misaligned(misaligned), .region_err(region_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] encode(input logic [31:0] t, input logic [31:0] p);
        logic [31:0] p4;
        p4 = p + 32'd4;
        return {t[27:2], t[1:0] != 2'b00, (t >> 28) != (p4 >> 28)};
    endfunction

    // reference model: an in-order queue of at most two pending results
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q.delete();
            m_enc = 0;
            m_err = 0;
        end else begin
            logic acc, dlv;
            acc = in_valid && q.size() < 2;
            dlv = out_ready && q.size() > 0;
            if (dlv) begin
                if (m_enc < SAT) m_enc++;
                if ((q[0][1] || q[0][0]) && m_err < SAT) m_err++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(encode(target, pc));
        end
    end

    always @(negedge Clk) if (Rst_n) begin
        check("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (out_valid && q.size() > 0) check("m_result", {4'b0, instr_index, misaligned, region_err}, {4'b0, q[0]});
        check("m_enc_count", 32'(enc_count), 32'(m_enc));
        check("m_err_count", 32'(err_count), 32'(m_err));
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic [31:0] t, input logic [31:0] p);
        in_valid = 1'b1;
        target = t;
        pc = p;
    endtask

    task automatic one(input logic [31:0] t, input logic [31:0] p, input logic [27:0] exp, input string name);
        out_ready = 1'b1;
        req(t, p);
        cyc();
        in_valid = 1'b0;
        check(name, {4'b0, out_valid, instr_index, misaligned, region_err}, {3'b0, 1'b1, exp});
        cyc();
    endtask

    initial begin
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_outputs", {instr_index, misaligned, region_err, enc_count}, 0);
        @(negedge Clk) Rst_n = 1'b1;
        cyc();
        // basic encode
        out_ready = 1'b1;
        req(32'h0040_0020, 32'h0040_0000);
        cyc();
        in_valid = 1'b0;
        check("basic_valid", 32'(out_valid), 1);
        check("basic_idx", 32'(instr_index), 32'h010_0008);
        check("basic_flags", {misaligned, region_err}, 0);
        cyc();
        check("basic_enc", 32'(enc_count), 1);
        // backpressure: A, B fill both entries, C waits
        out_ready = 1'b0;
        req(32'h0000_0100, 32'h0000_0000);
        cyc();
        req(32'h0000_0200, 32'h0000_0000);
        cyc();
        check("bp_ready_low", 32'(in_ready), 0);
        check("bp_head_a", 32'(instr_index), 32'h40);
        req(32'h0000_0300, 32'h0000_0000);
        cyc(2);
        check("bp_hold_a", 32'(instr_index), 32'h40);
        check("bp_still_full", 32'(in_ready), 0);
        out_ready = 1'b1;
        cyc();
        check("bp_head_b", 32'(instr_index), 32'h80);
        cyc();
        in_valid = 1'b0;
        check("bp_head_c", 32'(instr_index), 32'hC0);
        cyc();
        check("bp_enc", 32'(enc_count), 4);
        check("bp_empty", 32'(out_valid), 0);
        // misaligned and region boundaries
        one(32'h0040_0022, 32'h0040_0000, {26'h010_0008, 1'b1, 1'b0}, "misaligned");
        check("mis_err_count", 32'(err_count), 1);
        one(32'h1000_0000, 32'h0FFF_FFFC, {26'h0, 1'b0, 1'b0}, "region_carry_ok");
        one(32'h1000_0000, 32'h0FFF_FFF8, {26'h0, 1'b0, 1'b1}, "region_cross");
        one(32'h0000_0010, 32'hFFFF_FFFC, {26'h4, 1'b0, 1'b0}, "region_wrap");
        check("region_err_count", 32'(err_count), 2);
        // reset while both entries are full
        out_ready = 1'b0;
        req(32'h0000_0400, 32'h0000_0000);
        cyc(2);
        in_valid = 1'b0;
        check("two_full", 32'(in_ready), 0);
        #2 Rst_n = 1'b0;
        #1;
        check("two_rst_valid", 32'(out_valid), 0);
        check("two_rst_ready", 32'(in_ready), 1);
        check("two_rst_outputs", {instr_index, misaligned, region_err, enc_count, err_count}, 0);
        @(negedge Clk) Rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(3);
        check("two_no_stale", 32'(out_valid), 0);
        // saturation with mixed backpressure
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 3) != 0;
            req($urandom, $urandom);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc(3);
        check("enc_saturated", 32'(enc_count), SAT);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
